mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single physical memory port (MemContrl / DPI pmem).
- Requesters: IFU (read-only) and LSU (read/write).
- Converts each requester's valid/ready request plus valid/ready response into one registered, stable memory access held for LAT cycles.
- Sits between the core front-end/LSU and the memory model; one transaction in flight at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LAT, 1, cycles mem_valid is held per access, >=1; rdata is sampled on the last cycle. LAT=0 is illegal and must fail an elaboration assertion.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_raddr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU read data valid
- ifu_resp_ready  in  1  IFU takes response
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_wen  in  1  1 = write, 0 = read
- lsu_addr  in  ADDR_W  LSU address
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  8  byte write mask, passed unchanged
- lsu_resp_valid  out  1  LSU response (read data or write ack)
- lsu_resp_ready  in  1  LSU takes response
- lsu_rdata  out  DATA_W  LSU read data; 0 for write acks
- mem_valid  out  1  memory access active
- mem_wen  out  1  write enable; forced 0 when mem_valid=0
- mem_raddr, mem_waddr  out  ADDR_W  access address, both driven from the latched address
- mem_wdata  out  DATA_W  write data
- mem_wmask  out  8  write mask; 0 when idle or on reads
- mem_rdata  in  DATA_W  combinational read data from memory

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, named reset.
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE, arbitration:
  - Combinational 2-way round-robin grant from the two req_valid inputs.
  - On a tie, grant the requester not in last_grant.
  - Only the granted requester sees req_ready=1. A ready that depends on valid is permitted.
  - ready=0 for both outside IDLE.
- IDLE, handshake (valid&&ready):
  - Latch owner, wen (IFU forces 0), addr, wdata, and wmask (0 on reads).
  - Update last_grant, load cnt=LAT-1, go to ACCESS.
- ACCESS:
  - mem_valid=1 with all mem_* driven from the latched registers, stable for exactly LAT cycles.
  - A write is therefore presented once with constant values.
  - cnt decrements each cycle.
  - When cnt==0: capture mem_rdata into rdata_q (0 if wen), go to RESP.
- RESP:
  - Owner's resp_valid=1 with rdata_q held stable; the non-owner's resp_valid=0.
  - On resp_ready, go to IDLE next cycle.
  - resp_valid must not drop without resp_ready.
- Latency: accept at cycle t; mem_valid over t+1..t+LAT; resp_valid from t+LAT+1.
- Throughput: peak one transaction per LAT+2 cycles.
- Response data: rdata outputs show rdata_q only while that requester's resp_valid=1, else 0.
- No reordering or buffering beyond one transaction. Requests arriving in ACCESS/RESP wait with ready=0; requesters must hold valid and payload.
- Reset values: state=IDLE, mem_valid=0, mem_wen=0, mem addr/data/mask=0, both resp_valid=0, rdata_q=0, cnt=0, last_grant=IFU (LSU wins the first tie).
- Reset mid-operation:
  - Transaction abandoned, no response.
  - mem_valid=0 from the cycle after the reset edge.
  - A write already presented to memory is considered committed.
- Simultaneous resp_ready and new req_valid in RESP: the new request waits one cycle and is accepted in IDLE.
- No alignment or sign handling; the LSU extracts bytes.

Decomposition:
- Package mem_arb_pkg: state enum {IDLE, ACCESS, RESP}; owner enum {OWN_IFU, OWN_LSU}; ADDR_W/DATA_W defaults; MASK_W=8.
- One sub-module: rr_arb2 (2-way round-robin grant: inputs req[1:0] and last; output one-hot grant).
- Counter width is $clog2(LAT+1).

Test Plan:
1. LAT=2, IFU read addr 0x80000000, mem_rdata=0x00000413 -> mem_valid=1 with mem_raddr=0x80000000 on cycles 1-2; ifu_resp_valid=1, ifu_rdata=0x00000413 from cycle 3; lsu_resp_valid=0.
2. After reset, both req_valid held high for 4 transactions with resp_ready=1 -> grant order LSU, IFU, LSU, IFU.
3. LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F, LAT=1 -> one mem_valid cycle with mem_wen=1 and those values; lsu_resp_valid with lsu_rdata=0; mem_wen=0 afterwards.
4. IFU read with ifu_resp_ready low 5 cycles, lsu_req_valid high -> ifu_resp_valid and rdata stable; lsu_req_ready=0; mem_valid=0 throughout; LSU granted only after the IFU handshake.
5. Reset asserted during ACCESS (LAT=3, cycle 2) -> mem_valid=0 and resp_valid=0 next cycle; a following tie grants LSU.
6. Back-to-back IFU-only reads, LAT=1, resp_ready=1 -> one accept every 3 cycles; ifu_req_ready low in ACCESS and RESP.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int MASK_W     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: bit 0 = IFU, bit 1 = LSU; a tie goes to the
// requester that did not win last time.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] grant
);

    // One-hot grant decode from the request pair and the previous winner
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == OWN_IFU) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IFU and LSU onto the single memory port; one transaction in
// flight, each access held stable on the memory bus for LAT cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_raddr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_valid,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Width guarded so an illegal LAT still elaborates far enough to report
    localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    if (LAT < 1) begin : g_lat_illegal
        $error("mem_arbiter: LAT must be at least 1");
    end

    state_t            state_r;
    state_t            state_s;
    owner_t            owner_r;
    owner_t            last_r;
    logic              wen_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [MASK_W-1:0] wmask_r;
    logic [DATA_W-1:0] rdata_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        grant_s;
    logic              accept_s;
    logic              resp_ready_s;
    logic              lsu_win_s;

    rr_arb2 u_rr_arb2 (
        .req   ({lsu_req_valid, ifu_req_valid}),
        .last  (last_r),
        .grant (grant_s)
    );

    assign ifu_req_ready = (state_r == IDLE) && grant_s[0];
    assign lsu_req_ready = (state_r == IDLE) && grant_s[1];
    assign accept_s      = ifu_req_ready || lsu_req_ready;
    assign lsu_win_s     = grant_s[1];
    assign resp_ready_s  = (owner_r == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

    // Next-state decode for the IDLE -> ACCESS -> RESP sequence
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = RESP;
                end else begin
                    state_s = ACCESS;
                end
            end
            RESP: begin
                if (resp_ready_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, latched request payload, access counter and captured read data
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= OWN_IFU;
            last_r  <= OWN_IFU;
            wen_r   <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            wmask_r <= {MASK_W{1'b0}};
            rdata_r <= {DATA_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        owner_r <= lsu_win_s ? OWN_LSU : OWN_IFU;
                        last_r  <= lsu_win_s ? OWN_LSU : OWN_IFU;
                        wen_r   <= lsu_win_s && lsu_wen;
                        addr_r  <= lsu_win_s ? lsu_addr : ifu_raddr;
                        wdata_r <= lsu_win_s ? lsu_wdata : {DATA_W{1'b0}};
                        wmask_r <= (lsu_win_s && lsu_wen) ? lsu_wmask : {MASK_W{1'b0}};
                        cnt_r   <= CNT_LOAD;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                ACCESS: begin
                    // Read data is sampled on the final cycle of the access
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        rdata_r <= wen_r ? {DATA_W{1'b0}} : mem_rdata;
                    end else begin
                        cnt_r   <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign mem_valid      = (state_r == ACCESS);
    assign mem_wen        = mem_valid && wen_r;
    assign mem_raddr      = addr_r;
    assign mem_waddr      = addr_r;
    assign mem_wdata      = wdata_r;
    assign mem_wmask      = mem_valid ? wmask_r : {MASK_W{1'b0}};

    assign ifu_resp_valid = (state_r == RESP) && (owner_r == OWN_IFU);
    assign lsu_resp_valid = (state_r == RESP) && (owner_r == OWN_LSU);
    assign ifu_rdata      = ifu_resp_valid ? rdata_r : {DATA_W{1'b0}};
    assign lsu_rdata      = lsu_resp_valid ? rdata_r : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with LAT=2: latency, round-robin order,
// write presentation, response back-pressure, mid-access reset, throughput.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_raddr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask, mem_wmask;
    logic        mem_valid, mem_wen;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_raddr      (ifu_raddr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_ready (ifu_resp_ready),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_wen        (lsu_wen),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_ready (lsu_resp_ready),
        .lsu_rdata      (lsu_rdata),
        .mem_valid      (mem_valid),
        .mem_wen        (mem_wen),
        .mem_raddr      (mem_raddr),
        .mem_waddr      (mem_waddr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_rdata      (mem_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset          = 1'b1;
        ifu_req_valid  = 1'b0;
        ifu_raddr      = 32'h0;
        ifu_resp_ready = 1'b0;
        lsu_req_valid  = 1'b0;
        lsu_wen        = 1'b0;
        lsu_addr       = 32'h0;
        lsu_wdata      = 32'h0;
        lsu_wmask      = 8'h0;
        lsu_resp_ready = 1'b0;
        mem_rdata      = 32'h0;
        step();
        step();
        reset = 1'b0;
        #1;
        check_val("rst_mem_valid", 32'(mem_valid), 32'd0);
        check_val("rst_mem_wen", 32'(mem_wen), 32'd0);
        check_val("rst_mem_raddr", mem_raddr, 32'h0);
        check_val("rst_mem_wdata", mem_wdata, 32'h0);
        check_val("rst_mem_wmask", 32'(mem_wmask), 32'h0);
        check_val("rst_ifu_resp_valid", 32'(ifu_resp_valid), 32'd0);
        check_val("rst_lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);

        // IFU read: accept, two mem_valid cycles, response from the third
        ifu_req_valid = 1'b1;
        ifu_raddr     = 32'h8000_0000;
        mem_rdata     = 32'h0000_0413;
        #1;
        check_val("t1_ifu_ready", 32'(ifu_req_ready), 32'd1);
        check_val("t1_lsu_ready", 32'(lsu_req_ready), 32'd0);
        step();
        ifu_req_valid = 1'b0;
        ifu_raddr     = 32'h0;
        #1;
        check_val("t1_c1_mem_valid", 32'(mem_valid), 32'd1);
        check_val("t1_c1_raddr", mem_raddr, 32'h8000_0000);
        check_val("t1_c1_wen", 32'(mem_wen), 32'd0);
        check_val("t1_c1_ifu_ready", 32'(ifu_req_ready), 32'd0);
        step();
        check_val("t1_c2_mem_valid", 32'(mem_valid), 32'd1);
        check_val("t1_c2_raddr", mem_raddr, 32'h8000_0000);
        check_val("t1_c2_resp_valid", 32'(ifu_resp_valid), 32'd0);
        step();
        check_val("t1_c3_mem_valid", 32'(mem_valid), 32'd0);
        check_val("t1_c3_resp_valid", 32'(ifu_resp_valid), 32'd1);
        check_val("t1_c3_rdata", ifu_rdata, 32'h0000_0413);
        check_val("t1_c3_lsu_resp", 32'(lsu_resp_valid), 32'd0);
        ifu_resp_ready = 1'b1;
        step();
        ifu_resp_ready = 1'b0;
        check_val("t1_done_resp_valid", 32'(ifu_resp_valid), 32'd0);
        check_val("t1_done_rdata", ifu_rdata, 32'h0);

        // Round-robin from reset with both requesters always valid
        reset = 1'b1;
        step();
        reset          = 1'b0;
        ifu_req_valid  = 1'b1;
        lsu_req_valid  = 1'b1;
        lsu_wen        = 1'b0;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_val($sformatf("t2_lsu_ready_%0d", k), 32'(lsu_req_ready), 32'((k % 2) == 0));
            check_val($sformatf("t2_ifu_ready_%0d", k), 32'(ifu_req_ready), 32'((k % 2) == 1));
            step();
            step();
            step();
            check_val($sformatf("t2_lsu_resp_%0d", k), 32'(lsu_resp_valid), 32'((k % 2) == 0));
            check_val($sformatf("t2_ifu_resp_%0d", k), 32'(ifu_resp_valid), 32'((k % 2) == 1));
            step();
        end
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        ifu_resp_ready = 1'b0;

        // LSU write held constant for both access cycles, acked with zero data
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 8'h0F;
        mem_rdata     = 32'h0000_0413;
        #1;
        check_val("t3_lsu_ready", 32'(lsu_req_ready), 32'd1);
        step();
        lsu_req_valid = 1'b0;
        lsu_wen       = 1'b0;
        lsu_addr      = 32'h1111_1111;
        lsu_wdata     = 32'h2222_2222;
        lsu_wmask     = 8'hF0;
        for (int c = 0; c < LAT; c++) begin
            check_val($sformatf("t3_mem_valid_%0d", c), 32'(mem_valid), 32'd1);
            check_val($sformatf("t3_mem_wen_%0d", c), 32'(mem_wen), 32'd1);
            check_val($sformatf("t3_waddr_%0d", c), mem_waddr, 32'h8000_1000);
            check_val($sformatf("t3_wdata_%0d", c), mem_wdata, 32'hDEAD_BEEF);
            check_val($sformatf("t3_wmask_%0d", c), 32'(mem_wmask), 32'h0F);
            step();
        end
        check_val("t3_resp_valid", 32'(lsu_resp_valid), 32'd1);
        check_val("t3_resp_rdata", lsu_rdata, 32'h0);
        check_val("t3_resp_mem_wen", 32'(mem_wen), 32'd0);
        check_val("t3_resp_wmask", 32'(mem_wmask), 32'h0);
        step();
        check_val("t3_idle_resp_valid", 32'(lsu_resp_valid), 32'd0);
        check_val("t3_idle_mem_wen", 32'(mem_wen), 32'd0);
        lsu_resp_ready = 1'b0;

        // IFU response back-pressured while the LSU waits; last winner was LSU
        ifu_req_valid = 1'b1;
        ifu_raddr     = 32'h8000_0040;
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = 32'h8000_2000;
        mem_rdata     = 32'h1234_5678;
        #1;
        check_val("t4_ifu_ready", 32'(ifu_req_ready), 32'd1);
        check_val("t4_lsu_ready", 32'(lsu_req_ready), 32'd0);
        step();
        ifu_req_valid = 1'b0;
        #1;
        check_val("t4_access_lsu_ready", 32'(lsu_req_ready), 32'd0);
        step();
        step();
        mem_rdata = 32'hFFFF_0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_val($sformatf("t4_hold_valid_%0d", c), 32'(ifu_resp_valid), 32'd1);
            check_val($sformatf("t4_hold_rdata_%0d", c), ifu_rdata, 32'h1234_5678);
            check_val($sformatf("t4_hold_lsu_ready_%0d", c), 32'(lsu_req_ready), 32'd0);
            check_val($sformatf("t4_hold_mem_valid_%0d", c), 32'(mem_valid), 32'd0);
            step();
        end
        ifu_resp_ready = 1'b1;
        #1;
        check_val("t4_hs_resp_valid", 32'(ifu_resp_valid), 32'd1);
        check_val("t4_hs_lsu_ready", 32'(lsu_req_ready), 32'd0);
        step();
        ifu_resp_ready = 1'b0;
        #1;
        check_val("t4_idle_ifu_resp", 32'(ifu_resp_valid), 32'd0);
        check_val("t4_idle_lsu_ready", 32'(lsu_req_ready), 32'd1);
        step();
        lsu_req_valid  = 1'b0;
        lsu_resp_ready = 1'b1;
        #1;
        check_val("t4_lsu_raddr", mem_raddr, 32'h8000_2000);
        step();
        step();
        check_val("t4_lsu_resp_valid", 32'(lsu_resp_valid), 32'd1);
        check_val("t4_lsu_rdata", lsu_rdata, 32'hFFFF_0000);
        step();
        lsu_resp_ready = 1'b0;

        // Reset in the middle of an LSU access abandons it and restores last_grant
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_3000;
        step();
        lsu_req_valid = 1'b0;
        #1;
        check_val("t5_access_mem_valid", 32'(mem_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("t5_rst_mem_valid", 32'(mem_valid), 32'd0);
        check_val("t5_rst_lsu_resp", 32'(lsu_resp_valid), 32'd0);
        check_val("t5_rst_ifu_resp", 32'(ifu_resp_valid), 32'd0);
        step();
        step();
        check_val("t5_no_late_resp", 32'(lsu_resp_valid), 32'd0);
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        check_val("t5_tie_lsu_ready", 32'(lsu_req_ready), 32'd1);
        check_val("t5_tie_ifu_ready", 32'(ifu_req_ready), 32'd0);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        step();

        // Back-to-back IFU reads: one accept every LAT+2 cycles
        ifu_req_valid  = 1'b1;
        ifu_raddr      = 32'h8000_0100;
        ifu_resp_ready = 1'b1;
        for (int c = 0; c < 3 * (LAT + 2); c++) begin
            #1;
            check_val($sformatf("t6_ifu_ready_%0d", c), 32'(ifu_req_ready), 32'((c % (LAT + 2)) == 0));
            step();
        end
        ifu_req_valid  = 1'b0;
        ifu_resp_ready = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
